threshold_event_detector: RTL

//  Downstream consumer of the float threshold comparator's is_higher flag. Debounces the per-sample

---
 rtl/threshold_event_detector.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/threshold_event_detector.sv
// threshold_event_detector
//   Debounces the per-sample is_higher flag of a float threshold comparator into
//   a hysteretic alarm. ASSERT_CNT consecutive valid highs raise the alarm, and
//   RELEASE_CNT consecutive valid lows drop it. The block also produces one-cycle
//   rise and fall pulses and a saturating count of alarm rises.
//   Define PEAK_CAPTURE_EN to track the largest sample (IEEE-754 order) seen
//   since the last rise. Without it, peak and peak_valid are tied to zero.
//   Every output is registered. Cycles with sample_valid=0 leave all state unchanged.
module threshold_event_detector #(
   parameter int E_SIZE      = 8,
   parameter int C_SIZE      = 23,
   parameter int ASSERT_CNT  = 4,
   parameter int RELEASE_CNT = 4,
   parameter int CNT_W       = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     sample_valid,
   input  logic [C_SIZE+E_SIZE:0]   sample,
   input  logic                     is_higher,
   input  logic                     clear,
   output logic                     alarm,
   output logic                     alarm_rise,
   output logic                     alarm_fall,
   output logic [CNT_W-1:0]         event_count,
   output logic [C_SIZE+E_SIZE:0]   peak,
   output logic                     peak_valid
);

   localparam int MAX_RUN = (ASSERT_CNT > RELEASE_CNT) ? ASSERT_CNT : RELEASE_CNT;
   localparam int RUN_W   = $clog2(MAX_RUN + 1);

   // run_cnt holds the number of qualifying samples seen so far. Reaching the
   // last one means the current sample completes the run.
   localparam logic [RUN_W-1:0] ASSERT_LAST  = RUN_W'(ASSERT_CNT - 1);
   localparam logic [RUN_W-1:0] RELEASE_LAST = RUN_W'(RELEASE_CNT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      ALARM,
      RELEASING
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [RUN_W-1:0] run_cnt;
   logic [RUN_W-1:0] run_nxt;
   logic             rise_nxt;
   logic             fall_nxt;

   // Next-state, run counter and edge-event decode for the debounce FSM.
   always_comb begin
      // NOTE: every signal assigned here receives a default first, so no path can infer a latch.
      state_nxt = state;
      run_nxt   = run_cnt;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      if (sample_valid) begin
         case (state)
            IDLE: begin
               if (is_higher) begin
                  if (ASSERT_CNT == 1) begin
                     state_nxt = ALARM;
                     run_nxt   = '0;
                     rise_nxt  = 1'b1;
                  end else begin
                     state_nxt = ARMING;
                     run_nxt   = RUN_W'(1);
                  end
               end
            end
            ARMING: begin
               if (is_higher) begin
                  if (run_cnt == ASSERT_LAST) begin
                     state_nxt = ALARM;
                     run_nxt   = '0;
                     rise_nxt  = 1'b1;
                  end else begin
                     run_nxt = run_cnt + 1'b1;
                  end
               end else begin
                  state_nxt = IDLE;
                  run_nxt   = '0;
               end
            end
            ALARM: begin
               if (!is_higher) begin
                  if (RELEASE_CNT == 1) begin
                     state_nxt = IDLE;
                     run_nxt   = '0;
                     fall_nxt  = 1'b1;
                  end else begin
                     state_nxt = RELEASING;
                     run_nxt   = RUN_W'(1);
                  end
               end
            end
            RELEASING: begin
               if (!is_higher) begin
                  if (run_cnt == RELEASE_LAST) begin
                     state_nxt = IDLE;
                     run_nxt   = '0;
                     fall_nxt  = 1'b1;
                  end else begin
                     run_nxt = run_cnt + 1'b1;
                  end
               end else begin
                  state_nxt = ALARM;
                  run_nxt   = '0;
               end
            end
            default: begin
               state_nxt = IDLE;
               run_nxt   = '0;
            end
         endcase
      end
   end

   // State and run counter registers. Clear takes priority over any valid sample.
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (!reset_n) begin
         state   <= IDLE;
         run_cnt <= '0;
      end else if (clear) begin
         state   <= IDLE;
         run_cnt <= '0;
      end else begin
         state   <= state_nxt;
         run_cnt <= run_nxt;
      end
   end

   // Registered alarm level, edge pulses and saturating rise counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alarm       <= 1'b0;
         alarm_rise  <= 1'b0;
         alarm_fall  <= 1'b0;
         event_count <= '0;
      end else if (clear) begin
         alarm       <= 1'b0;
         alarm_rise  <= 1'b0;
         alarm_fall  <= 1'b0;
         event_count <= '0;
      end else begin
         alarm      <= (state_nxt == ALARM) || (state_nxt == RELEASING);
         alarm_rise <= rise_nxt;
         alarm_fall <= fall_nxt;
         if (rise_nxt && (event_count != {CNT_W{1'b1}})) begin
            event_count <= event_count + 1'b1;
         end
      end
   end

`ifdef PEAK_CAPTURE_EN
   localparam int W = C_SIZE + E_SIZE + 1;

   // IEEE-754 sign-magnitude "a > b". Under this rule +0 is greater than -0, and NaN is treated as an ordinary value.
   function automatic logic float_gt(input logic [W-1:0] a, input logic [W-1:0] b);
      logic a_neg;
      logic b_neg;
      a_neg = a[W-1];
      b_neg = b[W-1];
      if (a_neg != b_neg) begin
         float_gt = b_neg;
      end else if (!a_neg) begin
         float_gt = a[W-2:0] > b[W-2:0];
      end else begin
         float_gt = a[W-2:0] < b[W-2:0];
      end
   endfunction

   logic in_alarm;
   assign in_alarm = (state == ALARM) || (state == RELEASING);

   // Peak tracker. The rising sample seeds the peak. Any larger valid sample seen during the alarm replaces it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         peak       <= '0;
         peak_valid <= 1'b0;
      end else if (clear) begin
         peak       <= '0;
         peak_valid <= 1'b0;
      end else if (rise_nxt) begin
         peak       <= sample;
         peak_valid <= 1'b1;
      end else if (sample_valid && in_alarm && float_gt(sample, peak)) begin
         peak <= sample;
      end
   end
`else
   // Without peak capture, sample has no consumer.
   logic unused_sample;
   assign unused_sample = ^sample;
   assign peak          = '0;
   assign peak_valid    = 1'b0;
`endif

endmodule
